event_arbiter: RTL
==================

EVENT_ARBITER -- requirements
Module: event_arbiter

Interface
REQ-001 Parameter N_EVENTS, default 4, number of asynchronous event inputs (2..32) SHALL be supported.
REQ-002 Parameter STAGES, default 2, sets the synchronizer depth per input and SHALL be at least 2.
REQ-003 Port dest_clk, input, 1 bit, destination clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port rst_n, input, 1 bit, reset; it SHALL be synchronous and active-low.
REQ-005 Port evt_in, input, N_EVENTS bits, asynchronous event levels; events SHALL be defined as rising edges.
REQ-006 Port evt_mask, input, N_EVENTS bits, synchronous to dest_clk; 1 enables capture for that input.
REQ-007 Port evt_ready, input, 1 bit, consumer accept.
REQ-008 Port evt_valid, output, 1 bit, an event grant is presented.
REQ-009 Port evt_id, output, $clog2(N_EVENTS) bits, index of the granted event.
REQ-010 Port pending, output, N_EVENTS bits, registered pending-event flags.

Function
REQ-011 Each evt_in bit SHALL pass through a STAGES-deep flop chain tagged ASYNC_REG, then a 1-flop previous-value register.
REQ-012 Rising edge i SHALL be detected as sync_out[i] & ~prev[i].
REQ-013 A detected edge with evt_mask[i]=1 SHALL set pending[i] on the next edge; masked edges SHALL be dropped.
REQ-014 Deasserting evt_mask[i] SHALL NOT clear an already-set pending[i].
REQ-015 FSM states SHALL be IDLE and GRANT; evt_valid SHALL be 1 exactly in GRANT.
REQ-016 IDLE: if pending != 0, the FSM SHALL enter GRANT and latch evt_id = first set pending index at or above rr_ptr, wrapping modulo N_EVENTS.
REQ-017 GRANT: evt_id SHALL remain stable while evt_ready=0.
REQ-018 Handshake (evt_valid & evt_ready) SHALL clear pending[evt_id] and set rr_ptr = (evt_id+1) mod N_EVENTS.
REQ-019 On handshake, if any other pending bit, including bits set that cycle, remains set, the FSM SHALL stay in GRANT and present the next round-robin id the following cycle, giving back-to-back grants.
REQ-020 On handshake with no other pending bit set, the FSM SHALL return to IDLE.
REQ-021 A new edge on evt_id in the same cycle as its handshake SHALL leave pending[evt_id] set (set wins).
REQ-022 A new edge on an already-pending input SHALL merge into the one pending bit.
REQ-023 Latency SHALL be STAGES+2 rising edges from the first edge sampling evt_in high to evt_valid=1, with IDLE and the input unmasked.

Reset
REQ-024 While rst_n=0, sync flops, prev, pending, rr_ptr (0) and evt_id (0) SHALL clear, and the FSM SHALL go to IDLE.
REQ-025 All flops SHALL also carry these values as initial values.
REQ-026 Reset asserted in GRANT SHALL force evt_valid=0 on the next edge and discard all pending events.
REQ-027 An evt_in bit held high through reset SHALL produce one event after reset release.

Configuration
REQ-028 With macro EVT_ARB_OVERFLOW_EN defined, output overflow[N_EVENTS] and input ovf_clr[N_EVENTS] SHALL exist.
REQ-029 Under EVT_ARB_OVERFLOW_EN, overflow[i] SHALL become sticky-1 when an unmasked edge arrives while pending[i]=1 and pending[i] is not being cleared that cycle.
REQ-030 Under EVT_ARB_OVERFLOW_EN, ovf_clr[i] SHALL clear overflow[i], and a simultaneous overflow set SHALL win.
REQ-031 Without EVT_ARB_OVERFLOW_EN, those ports and registers SHALL be absent, and merged edges SHALL be silently dropped.

Verification (N_EVENTS=4, STAGES=2)
REQ-032 Single event: evt_in[2] 0->1, ready=1 -> evt_valid=1, evt_id=2 on the 4th edge; one-cycle pulse; pending returns to 0.
REQ-033 Round-robin: evt_in[0],[1],[3] rise together, ready=1 -> ids 0,1,3 on consecutive cycles, then evt_valid=0.
REQ-034 Fairness: rr_ptr=1 with events 0 and 1 pending -> id 1 granted before id 0.
REQ-035 Backpressure: ready=0 for 10 cycles while event 2 pending -> evt_id held at 2; edge on input 2 during hold -> one grant only (overflow[2]=1 when macro is defined).
REQ-036 Mask and reset: evt_mask[1]=0 with edge on input 1 -> no grant; reset asserted during GRANT -> evt_valid=0 next cycle, pending=0.

Source files
------------

// File: rtl/event_arbiter.sv
// event_arbiter: captures rising edges on asynchronous event inputs into
// destination-clock pending flags and grants them one at a time, in
// round-robin order, over a valid/ready handshake.
// Optional feature: define EVT_ARB_OVERFLOW_EN to add per-input sticky
// overflow flags (output overflow) with a per-input clear (input ovf_clr).
module event_arbiter #(
  parameter  int N_EVENTS = 4,
  parameter  int STAGES   = 2,
  localparam int ID_W     = $clog2(N_EVENTS)
) (
  input  logic                dest_clk,
  input  logic                rst_n,
  input  logic [N_EVENTS-1:0] evt_in,
  input  logic [N_EVENTS-1:0] evt_mask,
  input  logic                evt_ready,
  output logic                evt_valid,
  output logic [ID_W-1:0]     evt_id,
  output logic [N_EVENTS-1:0] pending
`ifdef EVT_ARB_OVERFLOW_EN
  ,
  output logic [N_EVENTS-1:0] overflow,
  input  logic [N_EVENTS-1:0] ovf_clr
`endif
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Synchronizer chain: index 0 is the first flop after the async input.
  (* ASYNC_REG = "TRUE" *)
  logic [STAGES-1:0][N_EVENTS-1:0] sync_chain = '0;
  logic [N_EVENTS-1:0]             prev_q     = '0;
  logic [N_EVENTS-1:0]             pend_q     = '0;
  state_t                          state      = IDLE;
  logic                            valid_q    = 1'b0;
  logic [ID_W-1:0]                 id_q       = '0;
  logic [ID_W-1:0]                 rr_ptr     = '0;

  logic [N_EVENTS-1:0] sync_out;
  logic [N_EVENTS-1:0] edge_det;
  logic [N_EVENTS-1:0] set_vec;
  logic [N_EVENTS-1:0] id_onehot;
  logic [N_EVENTS-1:0] clr_vec;
  logic [N_EVENTS-1:0] pending_nxt;
  logic [N_EVENTS-1:0] other_pending;
  logic [ID_W-1:0]     ptr_next;
  logic                hshake;

  // First set bit of vec at or above ptr, wrapping modulo N_EVENTS.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_EVENTS-1:0] vec,
                                              input logic [ID_W-1:0]     ptr);
    logic [ID_W-1:0] sel;
    logic            found;
    int              idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N_EVENTS; k++) begin
      idx = (int'(ptr) + k) % N_EVENTS;
      if (!found && vec[idx[ID_W-1:0]]) begin
        sel   = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign sync_out  = sync_chain[STAGES-1];
  assign edge_det  = sync_out & ~prev_q;
  assign set_vec   = edge_det & evt_mask;
  assign hshake    = valid_q & evt_ready;
  assign id_onehot = N_EVENTS'(1) << id_q;
  assign clr_vec   = hshake ? id_onehot : '0;
  // A new edge on the granted input in the handshake cycle keeps its bit set.
  assign pending_nxt   = (pend_q & ~clr_vec) | set_vec;
  assign other_pending = pending_nxt & ~id_onehot;
  assign ptr_next      = (id_q == ID_W'(N_EVENTS - 1)) ? '0 : id_q + 1'b1;

  // Resynchronize the event levels and keep the previous synchronized value.
  always_ff @(posedge dest_clk) begin
    if (!rst_n) begin
      sync_chain <= '0;
      prev_q     <= '0;
    end else begin
      if (STAGES > 1) begin
        sync_chain <= {sync_chain[STAGES-2:0], evt_in};
      end else begin
        sync_chain <= evt_in;
      end
      prev_q <= sync_out;
    end
  end

  // Pending flags: set by unmasked edges, cleared by the handshake.
  always_ff @(posedge dest_clk) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pending_nxt;
    end
  end

  // Grant FSM: latch a round-robin id, hold it until accepted.
  always_ff @(posedge dest_clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      id_q    <= '0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pend_q) begin
            state   <= GRANT;
            valid_q <= 1'b1;
            id_q    <= rr_pick(pend_q, rr_ptr);
          end
        end
        GRANT: begin
          if (evt_ready) begin
            rr_ptr <= ptr_next;
            if (|other_pending) begin
              id_q <= rr_pick(other_pending, ptr_next);
            end else begin
              state   <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef EVT_ARB_OVERFLOW_EN
  logic [N_EVENTS-1:0] ovf_q = '0;
  logic [N_EVENTS-1:0] ovf_set;

  // An edge that merges into a bit that stays pending is an overflow.
  assign ovf_set = set_vec & pend_q & ~clr_vec;

  // Sticky overflow flags; a new overflow beats a simultaneous clear.
  always_ff @(posedge dest_clk) begin
    if (!rst_n) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= (ovf_q & ~ovf_clr) | ovf_set;
    end
  end

  assign overflow = ovf_q;
`endif

  assign evt_valid = valid_q;
  assign evt_id    = id_q;
  assign pending   = pend_q;

endmodule
